// File: rtl/ahp_slave_pkg.sv
// Shared AHB-style definitions used by the ahp master and slave blocks.
//   htrans_e    : HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
//   hburst_e    : HBURST codes
//   hsize_e     : HSIZE codes
//   mst_state_e : master sequencing FSM states
//   burst_beats / burst_is_wrap : burst-code decode helpers
package ahp_slave_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HburstSingle = 3'd0,
    HburstIncr   = 3'd1,
    HburstWrap4  = 3'd2,
    HburstIncr4  = 3'd3,
    HburstWrap8  = 3'd4,
    HburstIncr8  = 3'd5,
    HburstWrap16 = 3'd6,
    HburstIncr16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    HsizeByte = 2'd0,
    HsizeHalf = 2'd1,
    HsizeWord = 2'd2,
    HsizeRsvd = 2'd3
  } hsize_e;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StBurst,
    StLast
  } mst_state_e;

  // Undefined-length INCR is issued as a single beat.
  function automatic logic [4:0] burst_beats(input logic [2:0] burst);
    logic [4:0] beats;
    case (hburst_e'(burst))
      HburstWrap4, HburstIncr4:   beats = 5'd4;
      HburstWrap8, HburstIncr8:   beats = 5'd8;
      HburstWrap16, HburstIncr16: beats = 5'd16;
      default:                    beats = 5'd1;
    endcase
    return beats;
  endfunction

  function automatic logic burst_is_wrap(input logic [2:0] burst);
    return (hburst_e'(burst) == HburstWrap4) || (hburst_e'(burst) == HburstWrap8) ||
           (hburst_e'(burst) == HburstWrap16);
  endfunction

endpackage

// File: rtl/ahp_addr_gen.sv
// Combinational next-beat address for an AHB burst.
//   haddr_i     : current beat address
//   hsize_i     : beat size code (bytes = 1 << hsize_i)
//   hburst_i    : burst code; WRAPx wraps within a (beats << size)-byte window
//   next_addr_o : address of the following beat
import ahp_slave_pkg::*;

module ahp_addr_gen (
  input  logic [31:0] haddr_i,
  input  logic [1:0]  hsize_i,
  input  logic [2:0]  hburst_i,
  output logic [31:0] next_addr_o
);

  logic [31:0] incr_addr;
  logic [31:0] wrap_mask;

  always_comb begin
    incr_addr = haddr_i + (32'd1 << hsize_i);
    // Window size is a power of two, so size-1 masks the wrapping low bits.
    wrap_mask = ({27'd0, burst_beats(hburst_i)} << hsize_i) - 32'd1;
    if (burst_is_wrap(hburst_i)) begin
      next_addr_o = (haddr_i & ~wrap_mask) | (incr_addr & wrap_mask);
    end else begin
      next_addr_o = incr_addr;
    end
  end

endmodule

// File: rtl/ahp_master.sv
// AHB burst master: accepts one burst command at a time and runs it on the bus.
//   HCLK/HRESETn                  : clock, async active-low reset
//   cmd_*                         : burst command handshake (ready only when idle)
//   wdata_valid/wdata/wdata_ready : write beat source, consumed when its address phase advances
//   rdata_valid/rdata/rdata_last  : read beat returned as each read data phase completes
//   done/err                      : one-cycle pulses for completion / reject or timeout abort
//   HSEL..HWDATA, HREADY, HRDATA  : AHB master-side bus signals
// The write source must hold wdata_valid until wdata_ready; BUSY beats may then only turn
// into SEQ, never the reverse, while a wait state is in progress.
import ahp_slave_pkg::*;

module ahp_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [2:0]  cmd_burst,
  input  logic        wdata_valid,
  input  logic [31:0] wdata,
  output logic        wdata_ready,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        rdata_last,
  output logic        done,
  output logic        err,
  output logic        HSEL,
  output logic        HWRITE,
  output htrans_e     HTRANS,
  output logic [2:0]  HBURST,
  output logic [1:0]  HSIZE,
  output logic [31:0] HADDR,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  mst_state_e       state_q;
  logic             write_q;
  logic [1:0]       size_q;
  logic [2:0]       burst_q;
  logic [31:0]      addr_q;
  logic [4:0]       beats_q;   // beats whose address phase is still to be issued
  logic [31:0]      hwdata_q;
  logic             dphase_q;  // a data phase of ours is on the bus this cycle
  logic             dlast_q;   // that data phase is the final beat
  logic [WaitW-1:0] wait_q;
  logic             done_q;
  logic             err_q;

  logic        beat_go;
  logic        stall;
  logic        advance;
  logic        timeout;
  logic        reject;
  logic        misalign;
  logic [10:0] span_end;
  logic [31:0] next_addr;

  ahp_addr_gen u_addr_gen (
    .haddr_i    (addr_q),
    .hsize_i    (size_q),
    .hburst_i   (burst_q),
    .next_addr_o(next_addr)
  );

  always_comb begin
    beat_go = !write_q || wdata_valid;
    stall   = dphase_q && !HREADY;
    timeout = stall && (wait_q == WaitW'(TIMEOUT - 1));
    advance = ((state_q == StAddr) || (state_q == StBurst)) && beat_go && !stall;

    HTRANS = HtransIdle;
    HSEL   = 1'b0;
    unique case (state_q)
      StAddr: begin
        // First write beat without data keeps the bus idle rather than BUSY.
        if (beat_go) begin
          HTRANS = HtransNonseq;
          HSEL   = 1'b1;
        end
      end
      StBurst: begin
        HTRANS = beat_go ? HtransSeq : HtransBusy;
        HSEL   = 1'b1;
      end
      default: ;
    endcase

    cmd_ready   = (state_q == StIdle);
    wdata_ready = advance && write_q;
    rdata_valid = dphase_q && !write_q && HREADY;
    rdata       = rdata_valid ? HRDATA : 32'd0;
    rdata_last  = rdata_valid && dlast_q;
    HWRITE      = write_q && (state_q != StIdle);
    HBURST      = burst_q;
    HSIZE       = size_q;
    HADDR       = addr_q;
    HWDATA      = hwdata_q;
    done        = done_q;
    err         = err_q;

    misalign = ((cmd_size == 2'd1) && cmd_addr[0]) || ((cmd_size == 2'd2) && (|cmd_addr[1:0]));
    span_end = {1'b0, cmd_addr[9:0]} + ({6'd0, burst_beats(cmd_burst)} << cmd_size);
    reject   = (cmd_size == 2'b11) || misalign ||
               (!burst_is_wrap(cmd_burst) && (span_end > 11'd1024));
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      size_q   <= 2'd0;
      burst_q  <= 3'd0;
      addr_q   <= 32'd0;
      beats_q  <= 5'd0;
      hwdata_q <= 32'd0;
      dphase_q <= 1'b0;
      dlast_q  <= 1'b0;
      wait_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      wait_q <= stall ? wait_q + WaitW'(1) : '0;

      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            if (reject) begin
              err_q <= 1'b1;
            end else begin
              write_q <= cmd_write;
              size_q  <= cmd_size;
              burst_q <= cmd_burst;
              addr_q  <= cmd_addr;
              beats_q <= burst_beats(cmd_burst);
              state_q <= StAddr;
            end
          end
        end
        StAddr, StBurst: begin
          if (timeout) begin
            err_q    <= 1'b1;
            dphase_q <= 1'b0;
            wait_q   <= '0;
            state_q  <= StIdle;
          end else if (advance) begin
            if (write_q) begin
              hwdata_q <= wdata;
            end
            dphase_q <= 1'b1;
            dlast_q  <= (beats_q == 5'd1);
            beats_q  <= beats_q - 5'd1;
            if (beats_q != 5'd1) begin
              addr_q <= next_addr;
            end
            state_q <= (beats_q == 5'd1) ? StLast : StBurst;
          end else if (!stall) begin
            // A BUSY cycle lets the previous data phase finish with nothing behind it.
            dphase_q <= 1'b0;
          end
        end
        StLast: begin
          if (timeout) begin
            err_q    <= 1'b1;
            dphase_q <= 1'b0;
            wait_q   <= '0;
            state_q  <= StIdle;
          end else if (HREADY) begin
            dphase_q <= 1'b0;
            dlast_q  <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ahp_master.sv
// Directed bench for ahp_master with a small zero-wait memory slave model.
module tb_ahp_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic [2:0]  cmd_burst;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid, rdata_last, done, err;
  logic [31:0] rdata;
  logic        HSEL, HWRITE, HREADY;
  logic [1:0]  htrans;
  logic [2:0]  HBURST;
  logic [1:0]  HSIZE;
  logic [31:0] HADDR, HWDATA, HRDATA;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahp_master #(.TIMEOUT(16)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_size   (cmd_size),
    .cmd_burst  (cmd_burst),
    .wdata_valid(wdata_valid),
    .wdata      (wdata),
    .wdata_ready(wdata_ready),
    .rdata_valid(rdata_valid),
    .rdata      (rdata),
    .rdata_last (rdata_last),
    .done       (done),
    .err        (err),
    .HSEL       (HSEL),
    .HWRITE     (HWRITE),
    .HTRANS     (htrans),
    .HBURST     (HBURST),
    .HSIZE      (HSIZE),
    .HADDR      (HADDR),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HRDATA     (HRDATA)
  );

  // Slave model: word memory, captures NONSEQ/SEQ address phases, HREADY from the bench.
  logic [31:0] mem [0:255];
  logic        hready_tb;
  logic        sv_dvalid, sv_dwrite;
  logic [7:0]  sv_widx;

  assign HREADY = hready_tb;
  assign HRDATA = sv_dvalid ? mem[sv_widx] : 32'd0;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sv_dvalid <= 1'b0;
      sv_dwrite <= 1'b0;
      sv_widx   <= 8'd0;
    end else begin
      if (sv_dvalid && sv_dwrite && HREADY) mem[sv_widx] <= HWDATA;
      if (HREADY) begin
        sv_dvalid <= HSEL && htrans[1];
        sv_dwrite <= HWRITE;
        sv_widx   <= HADDR[9:2];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  // Offer a command for one cycle; returns just after the accept edge.
  task automatic start_cmd(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                           input logic [2:0] burst);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_burst = burst;
    @(negedge HCLK);
    check_eq("cmd_ready_accept", cmd_ready, 1'b1);
    next_cycle();
    cmd_valid = 1'b0;
  endtask

  // Per-cycle vectors for the INCR4 write with a stalled third beat.
  logic        t2_wv    [7] = '{1, 1, 0, 0, 1, 1, 0};
  logic [31:0] t2_wd    [7] = '{32'hB0, 32'hB1, 0, 0, 32'hB2, 32'hB3, 0};
  logic [1:0]  t2_trans [7] = '{2'b10, 2'b11, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00};
  logic [31:0] t2_addr  [7] = '{32'h20, 32'h24, 32'h28, 32'h28, 32'h28, 32'h2C, 32'h2C};
  logic        t2_sel   [7] = '{1, 1, 1, 1, 1, 1, 0};

  // WRAP4 read at 0x38 over memory preloaded with E0..E3 at 0x30..0x3C.
  logic [1:0]  t3_trans [5] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
  logic [31:0] t3_addr  [5] = '{32'h38, 32'h3C, 32'h30, 32'h34, 32'h34};
  logic        t3_rv    [5] = '{0, 1, 1, 1, 1};
  logic [31:0] t3_rd    [5] = '{0, 32'hE2, 32'hE3, 32'hE0, 32'hE1};
  logic        t3_last  [5] = '{0, 0, 0, 0, 1};

  initial begin
    int wr_pulses;
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_size = 2'd0;
    cmd_burst = 3'd0; wdata_valid = 1'b0; wdata = 32'd0; hready_tb = 1'b1;
    repeat (2) next_cycle();
    HRESETn = 1'b1;
    @(negedge HCLK);
    check_eq("rst_cmd_ready", cmd_ready, 1'b1);
    check_eq("rst_htrans", htrans, 2'b00);
    check_eq("rst_hsel", HSEL, 1'b0);
    check_eq("rst_haddr", HADDR, 32'h0);
    check_eq("rst_done_err", {done, err}, 2'b00);
    next_cycle();

    // SINGLE write then SINGLE read back.
    wdata_valid = 1'b1; wdata = 32'hA5A5_1234;
    start_cmd(1'b1, 32'h10, 2'd2, 3'd0);
    @(negedge HCLK);
    check_eq("t1_nonseq", htrans, 2'b10);
    check_eq("t1_hsel", HSEL, 1'b1);
    check_eq("t1_haddr", HADDR, 32'h10);
    check_eq("t1_hwrite", HWRITE, 1'b1);
    check_eq("t1_wready", wdata_ready, 1'b1);
    next_cycle();
    wdata_valid = 1'b0;
    @(negedge HCLK);
    check_eq("t1_dphase_idle", htrans, 2'b00);
    check_eq("t1_hwdata", HWDATA, 32'hA5A5_1234);
    check_eq("t1_no_early_done", done, 1'b0);
    next_cycle();
    @(negedge HCLK);
    check_eq("t1_done", done, 1'b1);
    check_eq("t1_ready_again", cmd_ready, 1'b1);
    next_cycle();
    start_cmd(1'b0, 32'h10, 2'd2, 3'd0);
    @(negedge HCLK);
    check_eq("t1r_nonseq", htrans, 2'b10);
    check_eq("t1r_hwrite", HWRITE, 1'b0);
    next_cycle();
    @(negedge HCLK);
    check_eq("t1r_rvalid", rdata_valid, 1'b1);
    check_eq("t1r_rdata", rdata, 32'hA5A5_1234);
    check_eq("t1r_rlast", rdata_last, 1'b1);
    next_cycle();
    @(negedge HCLK);
    check_eq("t1r_done", done, 1'b1);
    next_cycle();

    // INCR4 write at 0x20 with beat 3 data held off for two cycles.
    wr_pulses = 0;
    start_cmd(1'b1, 32'h20, 2'd2, 3'd3);
    for (int i = 0; i < 7; i++) begin
      wdata_valid = t2_wv[i];
      wdata       = t2_wd[i];
      @(negedge HCLK);
      check_eq($sformatf("t2_htrans_c%0d", i), htrans, t2_trans[i]);
      check_eq($sformatf("t2_hsel_c%0d", i), HSEL, t2_sel[i]);
      if (t2_sel[i]) check_eq($sformatf("t2_haddr_c%0d", i), HADDR, t2_addr[i]);
      if (wdata_ready) wr_pulses++;
      next_cycle();
    end
    wdata_valid = 1'b0;
    @(negedge HCLK);
    check_eq("t2_done", done, 1'b1);
    check_eq("t2_wready_pulses", wr_pulses, 4);
    check_eq("t2_mem20", mem[8], 32'hB0);
    check_eq("t2_mem24", mem[9], 32'hB1);
    check_eq("t2_mem28", mem[10], 32'hB2);
    check_eq("t2_mem2c", mem[11], 32'hB3);
    next_cycle();

    // Preload 0x30..0x3C with an INCR4 write, then WRAP4 read at 0x38.
    start_cmd(1'b1, 32'h30, 2'd2, 3'd3);
    for (int i = 0; i < 4; i++) begin
      wdata_valid = 1'b1;
      wdata       = 32'hE0 + i;
      @(negedge HCLK);
      check_eq($sformatf("t3w_wready_b%0d", i), wdata_ready, 1'b1);
      next_cycle();
    end
    wdata_valid = 1'b0;
    next_cycle();
    @(negedge HCLK);
    check_eq("t3w_done", done, 1'b1);
    next_cycle();
    start_cmd(1'b0, 32'h38, 2'd2, 3'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      check_eq($sformatf("t3_htrans_c%0d", i), htrans, t3_trans[i]);
      if (t3_trans[i] != 2'b00) check_eq($sformatf("t3_haddr_c%0d", i), HADDR, t3_addr[i]);
      check_eq($sformatf("t3_rvalid_c%0d", i), rdata_valid, t3_rv[i]);
      if (t3_rv[i]) check_eq($sformatf("t3_rdata_c%0d", i), rdata, t3_rd[i]);
      check_eq($sformatf("t3_rlast_c%0d", i), rdata_last, t3_last[i]);
      next_cycle();
    end
    @(negedge HCLK);
    check_eq("t3_done", done, 1'b1);
    next_cycle();

    // Read with HREADY stuck low: abort after 16 wait cycles.
    start_cmd(1'b0, 32'h80, 2'd2, 3'd0);
    @(negedge HCLK);
    check_eq("t4_nonseq", htrans, 2'b10);
    check_eq("t4_haddr", HADDR, 32'h80);
    next_cycle();
    hready_tb = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge HCLK);
      check_eq($sformatf("t4_wait%0d_err", i), err, 1'b0);
      check_eq($sformatf("t4_wait%0d_rvalid", i), rdata_valid, 1'b0);
      next_cycle();
    end
    @(negedge HCLK);
    check_eq("t4_err", err, 1'b1);
    check_eq("t4_no_done", done, 1'b0);
    check_eq("t4_htrans", htrans, 2'b00);
    check_eq("t4_hsel", HSEL, 1'b0);
    check_eq("t4_cmd_ready", cmd_ready, 1'b1);
    hready_tb = 1'b1;
    next_cycle();
    @(negedge HCLK);
    check_eq("t4_err_pulse", err, 1'b0);
    check_eq("t4_no_done_after", done, 1'b0);
    next_cycle();

    // Rejected commands: 1KB crossing, misaligned word, reserved size.
    wdata_valid = 1'b1; wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) start_cmd(1'b1, 32'h3FC, 2'd2, 3'd3);
      else if (k == 1) start_cmd(1'b1, 32'h02, 2'd2, 3'd0);
      else start_cmd(1'b0, 32'h00, 2'd3, 3'd0);
      @(negedge HCLK);
      check_eq($sformatf("t5_err_%0d", k), err, 1'b1);
      check_eq($sformatf("t5_hsel_%0d", k), HSEL, 1'b0);
      check_eq($sformatf("t5_idle_%0d", k), cmd_ready, 1'b1);
      check_eq($sformatf("t5_wready_%0d", k), wdata_ready, 1'b0);
      next_cycle();
      @(negedge HCLK);
      check_eq($sformatf("t5_err_clr_%0d", k), err, 1'b0);
      check_eq($sformatf("t5_hsel_clr_%0d", k), HSEL, 1'b0);
      next_cycle();
    end
    wdata_valid = 1'b0;

    // INCR4 ending exactly at the 1KB boundary is legal.
    start_cmd(1'b0, 32'h3F0, 2'd2, 3'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      check_eq($sformatf("t5b_err_c%0d", i), err, 1'b0);
      check_eq($sformatf("t5b_haddr_c%0d", i), HADDR, 32'h3F0 + 32'(4 * i));
      next_cycle();
    end
    @(negedge HCLK);
    check_eq("t5b_last_idle", htrans, 2'b00);
    next_cycle();
    @(negedge HCLK);
    check_eq("t5b_done", done, 1'b1);
    next_cycle();

    // Reset during beat 2 of an INCR8 write, then a normal command.
    wdata_valid = 1'b1; wdata = 32'h7777_0000;
    start_cmd(1'b1, 32'h40, 2'd2, 3'd5);
    @(negedge HCLK);
    check_eq("t6_nonseq", htrans, 2'b10);
    next_cycle();
    @(negedge HCLK);
    check_eq("t6_beat2_seq", htrans, 2'b11);
    check_eq("t6_beat2_addr", HADDR, 32'h44);
    HRESETn = 1'b0;
    #1;
    check_eq("t6_rst_htrans", htrans, 2'b00);
    check_eq("t6_rst_hsel_hwrite", {HSEL, HWRITE}, 2'b00);
    check_eq("t6_rst_haddr", HADDR, 32'h0);
    check_eq("t6_rst_hwdata", HWDATA, 32'h0);
    check_eq("t6_rst_burst_size", {HBURST, HSIZE}, 5'd0);
    check_eq("t6_rst_pulses", {wdata_ready, rdata_valid, done, err}, 4'b0000);
    next_cycle();
    HRESETn = 1'b1;
    wdata_valid = 1'b0;
    @(negedge HCLK);
    check_eq("t6_post_ready", cmd_ready, 1'b1);
    check_eq("t6_post_done_err", {done, err}, 2'b00);
    next_cycle();
    start_cmd(1'b0, 32'h10, 2'd2, 3'd0);
    @(negedge HCLK);
    check_eq("t6_read_nonseq", htrans, 2'b10);
    next_cycle();
    @(negedge HCLK);
    check_eq("t6_read_rdata", rdata, 32'hA5A5_1234);
    next_cycle();
    @(negedge HCLK);
    check_eq("t6_read_done", done, 1'b1);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahp_master.md
AHP_MASTER -- requirements
Module: ahp_master

Interface
REQ-001 TIMEOUT, 16, max consecutive HREADY-low data-phase cycles before abort.
REQ-002 HCLK  in  1  bus clock; all state updates on rising edge.
REQ-003 HRESETn  in  1  asynchronous, active-low reset.
REQ-004 cmd_valid  in  1  burst command offered.
REQ-005 cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid&&cmd_ready.
REQ-006 cmd_write / cmd_addr / cmd_size / cmd_burst  in  1/32/2/3  direction, start byte address, beat size, AHB burst code.
REQ-007 wdata_valid / wdata  in  1/32  write beat source.
REQ-008 wdata_ready  out  1  write beat consumed this cycle.
REQ-009 rdata_valid / rdata / rdata_last  out  1/32/1  read beat returned, final-beat flag.
REQ-010 done / err  out  1/1  single-cycle pulses: burst complete / command rejected or aborted.
REQ-011 HSEL, HWRITE  out  1  slave select, transfer direction.
REQ-012 HTRANS  out  HTRANS_ENUM  IDLE/BUSY/NON_SEQ/SEQ.
REQ-013 HBURST / HSIZE / HADDR / HWDATA  out  3/2/32/32  AHB address- and data-phase signals.
REQ-014 HREADY / HRDATA  in  1/32  slave ready, read data.

Function
REQ-015 States: IDLE, ADDR (NON_SEQ beat), BURST (SEQ/BUSY beats), LAST (final data phase, HTRANS=IDLE).
REQ-016 Beats: SINGLE/INCR=1, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16.
REQ-017 Accept-cycle reject (err pulse, stay IDLE, no bus activity): cmd_size=2'b11, cmd_addr not aligned to size, or INCRx crossing a 1KB boundary.
REQ-018 Address phase occupies one cycle; data phase follows next cycle and extends while HREADY=0; HADDR/HTRANS/HSIZE/HBURST/HWRITE held stable while HREADY=0.
REQ-019 INCR next address = HADDR + (1<<HSIZE); WRAP keeps bits above log2(beats<<HSIZE) fixed, increments and wraps the bits below.
REQ-020 Write: wdata sampled (wdata_ready=1) in the address-phase cycle in which the beat advances; HWDATA drives that registered value in its data phase.
REQ-021 Write beat with wdata_valid=0: drive BUSY (first beat: stay HTRANS=IDLE, HSEL=0), no wdata_ready, address unchanged; resume SEQ/NON_SEQ when wdata_valid=1.
REQ-022 Read: rdata_valid=1, rdata=HRDATA in each cycle a read data phase completes (HREADY=1); rdata_last on final beat.
REQ-023 HSEL=1 exactly during NON_SEQ/SEQ/BUSY address phases; otherwise 0.
REQ-024 done pulses the cycle after the final data phase completes; cmd_ready returns high that same cycle.
REQ-025 Wait counter resets on each HREADY=1; reaching TIMEOUT in a data phase: err pulse, HTRANS=IDLE, HSEL=0, return IDLE, no done, remaining beats dropped.
REQ-026 Single-beat and last-beat data phases overlap HTRANS=IDLE; no back-to-back command pipelining across bursts.

Reset
REQ-027 HRESETn low (any time, mid-burst included): state IDLE, HTRANS=IDLE, HSEL/HWRITE/cmd-side pulses/wdata_ready/rdata_valid=0, HADDR/HWDATA/rdata/HBURST/HSIZE=0, cmd_ready=1 after release; burst abandoned, no done/err.
REQ-028 Wait counter and beat counter cleared on reset.

Structure
REQ-029 HTRANS_ENUM (IDLE=00, BUSY=01, NON_SEQ=10, SEQ=11), HBURST codes, HSIZE codes and the master state enum live in shared package AHP_SLAVE_PKG, used by slave and master.
REQ-030 Sub-module ahp_addr_gen: combinational next-address (INCR/WRAP) from HADDR, HSIZE, HBURST.

Verification
REQ-031 SINGLE word write 0xA5A5_1234 to 0x10 -> NON_SEQ one cycle, HWDATA=0xA5A5_1234 next cycle, done; slave readback via SINGLE read returns same value.
REQ-032 INCR4 word write at 0x20, wdata_valid low for beat 3 two cycles -> HADDR 20,24,(BUSY x2 at 28),28,2C, four wdata_ready pulses.
REQ-033 WRAP4 word read at 0x38 -> HADDR 38,3C,30,34; four rdata_valid, rdata_last on beat 4.
REQ-034 Read of never-written 0x80 (HREADY held 0) -> err after 16 wait cycles, HTRANS=IDLE, no done.
REQ-035 cmd_addr=0x3FC INCR4 word, and cmd_addr=0x02 word -> err pulse, no HSEL activity.
REQ-036 HRESETn asserted during beat 2 of INCR8 -> outputs at reset values immediately; next command executes normally.
